// File: rtl/jt08_adpcmb_pkg.sv
// Shared definitions for the ADPCM-B encoder and playback decoder: delta limits,
// step-scale table and encoder FSM encoding.
package jt08_adpcmb_pkg;

  localparam logic [14:0] DELTA_MIN = 15'd127;
  localparam logic [14:0] DELTA_MAX = 15'd24576;

  // Delta scale factors in 1/64 units, indexed by nibble magnitude.
  localparam logic [7:0] STEP_K [8] = '{
    8'd57, 8'd57, 8'd57, 8'd57, 8'd77, 8'd102, 8'd128, 8'd153
  };

  typedef enum logic [3:0] {
    StIdle,
    StDiff,
    StQ2,
    StQ1,
    StQ0,
    StRecon,
    StStep,
    StPack,
    StWrite
  } state_e;

  function automatic logic [7:0] step_k(input logic [2:0] m);
    return STEP_K[m];
  endfunction

endpackage

// File: rtl/jt08_adpcmb_step.sv
// ADPCM-B reconstruction and step update: next accumulator and next delta
// from one nibble, shared by the encoder and the playback decoder.
module jt08_adpcmb_step
  import jt08_adpcmb_pkg::*;
(
  input  logic [2:0]         m,
  input  logic               sign,
  input  logic signed [15:0] acc,
  input  logic [14:0]        delta,
  output logic signed [15:0] acc_nxt,
  output logic [14:0]        delta_nxt
);

  logic [18:0]        prod;
  logic [15:0]        diff;
  logic signed [17:0] acc_x;
  logic signed [17:0] diff_x;
  logic signed [17:0] sum;
  logic [21:0]        scaled;
  logic [15:0]        dnew;

  always_comb begin
    // (2m+1)*delta as shift-add, then /8
    prod = {4'd0, delta};
    if (m[0]) prod = prod + {3'd0, delta, 1'b0};
    if (m[1]) prod = prod + {2'd0, delta, 2'b0};
    if (m[2]) prod = prod + {1'b0, delta, 3'b0};
    diff   = 16'(prod >> 3);
    acc_x  = {{2{acc[15]}}, acc};
    diff_x = {2'b00, diff};
    sum    = sign ? (acc_x - diff_x) : (acc_x + diff_x);
    if (sum > 18'sd32767) begin
      acc_nxt = 16'sh7fff;
    end else if (sum < -18'sd32768) begin
      acc_nxt = 16'sh8000;
    end else begin
      acc_nxt = sum[15:0];
    end

    scaled = 22'(delta) * 22'(step_k(m));
    dnew   = 16'(scaled >> 6);
    if (dnew < 16'(DELTA_MIN)) begin
      delta_nxt = DELTA_MIN;
    end else if (dnew > 16'(DELTA_MAX)) begin
      delta_nxt = DELTA_MAX;
    end else begin
      delta_nxt = dnew[14:0];
    end
  end

endmodule

// File: rtl/jt08_adpcmb_enc.sv
// ADPCM-B record encoder: quantises PCM samples to nibbles, packs two per byte
// (high first) and writes them to ADPCM RAM between astart and aend.
module jt08_adpcmb_enc
  import jt08_adpcmb_pkg::*;
#(
  parameter int unsigned AW = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          on,
  input  logic          rep,
  input  logic          clr,
  input  logic [AW-1:0] astart,
  input  logic [AW-1:0] aend,
  input  logic          pcm_valid,
  input  logic [15:0]   pcm_in,
  output logic [23:0]   addr,
  output logic [7:0]    ram_dout,
  output logic          wr_req,
  input  logic          wr_ack,
  output logic [3:0]    nibble,
  output logic          busy,
  output logic          eos,
  output logic          ovf
);

  state_e             state_q, state_d;
  logic signed [15:0] pcm_q, pcm_d;
  logic signed [15:0] acc_q, acc_d, acc_nxt;
  logic [14:0]        delta_q, delta_d, delta_nxt;
  logic [15:0]        t_q, t_d;
  logic               sign_q, sign_d;
  logic [2:0]         m_q, m_d;
  logic [3:0]         hi_q, hi_d;
  logic [3:0]         nib_q, nib_d;
  logic               half_q, half_d;
  logic [7:0]         dout_q, dout_d;
  logic               wr_req_q, wr_req_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               eos_q, eos_d;
  logic               ovf_q, ovf_d;
  logic               on_q;
  logic signed [16:0] diff17;
  logic               on_rise;
  logic               b0;

  jt08_adpcmb_step u_step (
    .m         (m_q),
    .sign      (sign_q),
    .acc       (acc_q),
    .delta     (delta_q),
    .acc_nxt   (acc_nxt),
    .delta_nxt (delta_nxt)
  );

  assign on_rise = on & ~on_q;
  assign diff17  = {pcm_q[15], pcm_q} - {acc_q[15], acc_q};
  assign b0      = t_q >= {3'b000, delta_q[14:2]};

  always_comb begin
    state_d  = state_q;
    pcm_d    = pcm_q;
    acc_d    = acc_q;
    delta_d  = delta_q;
    t_d      = t_q;
    sign_d   = sign_q;
    m_d      = m_q;
    hi_d     = hi_q;
    nib_d    = nib_q;
    half_d   = half_q;
    dout_d   = dout_q;
    wr_req_d = wr_req_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    eos_d    = 1'b0;
    ovf_d    = ovf_q;

    if (pcm_valid && state_q != StIdle) ovf_d = 1'b1;

    // Losing 'on' aborts a sample immediately, but a pending write completes.
    if (!on && state_q != StWrite) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (pcm_valid && busy_q && on) begin
            pcm_d   = pcm_in;
            state_d = StDiff;
          end
        end
        StDiff: begin
          sign_d  = diff17[16];
          t_d     = 16'(diff17[16] ? -diff17 : diff17);
          m_d     = 3'd0;
          state_d = StQ2;
        end
        StQ2: begin
          if (t_q >= {1'b0, delta_q}) begin
            m_d[2] = 1'b1;
            t_d    = t_q - {1'b0, delta_q};
          end
          state_d = StQ1;
        end
        StQ1: begin
          if (t_q >= {2'b00, delta_q[14:1]}) begin
            m_d[1] = 1'b1;
            t_d    = t_q - {2'b00, delta_q[14:1]};
          end
          state_d = StQ0;
        end
        StQ0: begin
          m_d[0]  = b0;
          nib_d   = {sign_q, m_q[2:1], b0};
          state_d = StRecon;
        end
        StRecon: begin
          acc_d   = acc_nxt;
          state_d = StStep;
        end
        StStep: begin
          delta_d = delta_nxt;
          state_d = StPack;
        end
        StPack: begin
          if (!half_q) begin
            hi_d    = nib_q;
            half_d  = 1'b1;
            state_d = StIdle;
          end else begin
            dout_d   = {hi_q, nib_q};
            half_d   = 1'b0;
            wr_req_d = 1'b1;
            state_d  = StWrite;
          end
        end
        StWrite: begin
          if (wr_req_q && wr_ack) begin
            wr_req_d = 1'b0;
            state_d  = StIdle;
            if (addr_q != aend) begin
              addr_d = addr_q + AW'(1);
            end else begin
              eos_d = 1'b1;
              if (rep) addr_d = astart;
              else     busy_d = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (!on) half_d = 1'b0;

    if (on_rise) begin
      addr_d  = astart;
      acc_d   = '0;
      delta_d = DELTA_MIN;
      half_d  = 1'b0;
      ovf_d   = 1'b0;
      busy_d  = 1'b1;
    end

    if (state_d == StIdle && !on) busy_d = 1'b0;

    if (clr) begin
      state_d  = StIdle;
      half_d   = 1'b0;
      wr_req_d = 1'b0;
      acc_d    = '0;
      delta_d  = DELTA_MIN;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pcm_q    <= '0;
      acc_q    <= '0;
      delta_q  <= DELTA_MIN;
      t_q      <= '0;
      sign_q   <= 1'b0;
      m_q      <= '0;
      hi_q     <= '0;
      nib_q    <= '0;
      half_q   <= 1'b0;
      dout_q   <= '0;
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      eos_q    <= 1'b0;
      ovf_q    <= 1'b0;
      on_q     <= 1'b0;
    end else if (cen) begin
      state_q  <= state_d;
      pcm_q    <= pcm_d;
      acc_q    <= acc_d;
      delta_q  <= delta_d;
      t_q      <= t_d;
      sign_q   <= sign_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      nib_q    <= nib_d;
      half_q   <= half_d;
      dout_q   <= dout_d;
      wr_req_q <= wr_req_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      eos_q    <= eos_d;
      ovf_q    <= ovf_d;
      on_q     <= on;
    end
  end

  assign addr     = 24'(addr_q);
  assign ram_dout = dout_q;
  assign wr_req   = wr_req_q;
  assign nibble   = nib_q;
  assign busy     = busy_q;
  assign eos      = eos_q;
  assign ovf      = ovf_q;

endmodule
